// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus a WIDTH-cycle shift-add multiplier.
// State | meaning:  S_IDLE  ready for a request  |  S_MUL  multiply iterating  |  S_DONE  result valid
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       opcode,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] rout,
    output logic             out_valid,
    output logic [4:0]       flags,
    output logic             op_err
);
    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_NOT  = 8'h04;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDU = 8'h06;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_RSH  = 8'h08;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_ALSH = 8'h0C;
    localparam logic [7:0] OP_MUL  = 8'h0E;
    localparam logic [7:0] OP_ARSH = 8'h0F;
    localparam logic [7:0] OP_LSH  = 8'h84;

    localparam int FN = 4, FZ = 3, FF = 2, FL = 1, FC = 0;
    localparam int MSB = WIDTH - 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WVAL = WIDTH'(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
    state_t state, state_nxt;

    logic [2*WIDTH-1:0] mcand, acc, prod_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    logic               accept, is_mul, mul_last, unk;
    logic [WIDTH-1:0]   res;
    logic [4:0]         flg;
    logic [WIDTH:0]     sum;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid & in_ready;
    assign is_mul   = (opcode == OP_MUL);
    assign mul_last = (state == S_MUL) && (cnt == '0);
    assign prod_nxt = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = is_mul ? S_MUL : S_DONE;
            S_MUL:   if (mul_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Single-cycle result; unknown opcodes and MUL leave rout/flags as they are here.
    always_comb begin
        res = rout;
        flg = flags;
        unk = 1'b0;
        sum = '0;
        case (opcode)
            OP_AND:  res = r1 & r2;
            OP_OR:   res = r1 | r2;
            OP_XOR:  res = r1 ^ r2;
            OP_NOT:  res = ~r1;
            OP_ADD, OP_ADDU, OP_ADDC: begin
                sum = {1'b0, r1} + {1'b0, r2}
                    + {{WIDTH{1'b0}}, (opcode == OP_ADDC) ? flags[FC] : 1'b0};
                res = sum[MSB:0];
                flg[FC] = sum[WIDTH];
                if (opcode != OP_ADDU)
                    flg[FF] = (r1[MSB] == r2[MSB]) && (sum[MSB] != r1[MSB]);
            end
            OP_SUB: begin
                sum = {1'b0, r1} + {1'b0, ~r2} + {{WIDTH{1'b0}}, 1'b1};
                res = sum[MSB:0];
                flg[FC] = sum[WIDTH];
                flg[FF] = (r1[MSB] != r2[MSB]) && (sum[MSB] != r1[MSB]);
            end
            OP_CMP: begin
                flg[FZ] = (r1 == r2);
                flg[FL] = (r1 < r2);
                flg[FN] = ($signed(r1) < $signed(r2));
            end
            OP_LSH, OP_ALSH: res = (r1 >= WVAL) ? '0 : (r2 << r1);
            OP_RSH:          res = (r1 >= WVAL) ? '0 : (r2 >> r1);
            OP_ARSH:         res = (r1 >= WVAL) ? {WIDTH{r2[MSB]}} : WIDTH'($signed(r2) >>> r1);
            OP_MUL:  ;
            default: unk = 1'b1;
        endcase
        if (!unk && opcode != OP_CMP && opcode != OP_MUL) begin
            flg[FZ] = (res == '0);
            flg[FN] = res[MSB];
        end
    end

    // Multiplier: operands latched at accept so later input changes cannot disturb it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept && is_mul) begin
            mcand  <= {{WIDTH{1'b0}}, r1};
            mplier <= r2;
            acc    <= '0;
            cnt    <= CW'(WIDTH - 1);
        end else if (state == S_MUL) begin
            acc    <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rout      <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
            op_err    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            op_err    <= 1'b0;
            if (accept && !is_mul) begin
                rout      <= res;
                flags     <= flg;
                out_valid <= 1'b1;
                op_err    <= unk;
            end else if (mul_last) begin
                rout      <= prod_nxt[MSB:0];
                flags[FC] <= |prod_nxt[2*WIDTH-1:WIDTH];
                flags[FZ] <= (prod_nxt[MSB:0] == '0);
                flags[FN] <= prod_nxt[MSB];
                out_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16; expected values are hand-computed constants.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  opcode;
    logic [15:0] r1, r2, rout;
    logic        out_valid;
    logic [4:0]  flags;
    logic        op_err;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .r1(r1), .r2(r2), .rout(rout), .out_valid(out_valid),
        .flags(flags), .op_err(op_err)
    );

    always #5 clk = ~clk;

    // Drive one request once in_ready is seen; returns #1 after the accepting edge.
    task automatic issue(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready_timeout: in_ready=%b required 1", in_ready);
        end
        opcode = op; r1 = a; r2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; opcode = '0; r1 = '0; r2 = '0;
        #12;
        checks++; if (rout !== 16'h0) begin errors++; $display("FAIL reset_rout: got %h required 0000", rout); end
        checks++; if (flags !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b required 00000", flags); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (op_err !== 1'b0) begin errors++; $display("FAIL reset_op_err: got %b required 0", op_err); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_add();
        issue(8'h05, 16'h7FFF, 16'h0001);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid: got %b required 1", out_valid); end
        checks++; if (rout !== 16'h8000) begin errors++; $display("FAIL add_rout: got %h required 8000", rout); end
        checks++; if (flags !== 5'b10100) begin errors++; $display("FAIL add_flags: got %b required 10100", flags); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_busy: in_ready=%b required 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_pulse_width: out_valid=%b required 0", out_valid); end
    endtask

    task automatic test_addc();
        issue(8'h05, 16'hFFFF, 16'h0001);
        checks++; if (rout !== 16'h0000) begin errors++; $display("FAIL addc_first_rout: got %h required 0000", rout); end
        checks++; if (flags !== 5'b01001) begin errors++; $display("FAIL addc_first_flags: got %b required 01001", flags); end
        issue(8'h07, 16'h0000, 16'h0000);
        checks++; if (rout !== 16'h0001) begin errors++; $display("FAIL addc_rout: got %h required 0001", rout); end
        checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL addc_flags: got %b required 00000", flags); end
    endtask

    task automatic test_cmp();
        issue(8'h0B, 16'hFFFF, 16'h0001);
        checks++; if (rout !== 16'h0001) begin errors++; $display("FAIL cmp_rout_kept: got %h required 0001", rout); end
        checks++; if (flags !== 5'b10000) begin errors++; $display("FAIL cmp_flags: got %b required 10000", flags); end
        issue(8'h0B, 16'h0005, 16'h0005);
        checks++; if (flags !== 5'b01000) begin errors++; $display("FAIL cmp_eq_flags: got %b required 01000", flags); end
        issue(8'h0B, 16'h0001, 16'h0002);
        checks++; if (flags !== 5'b10010) begin errors++; $display("FAIL cmp_lt_flags: got %b required 10010", flags); end
    endtask

    task automatic test_logic();
        issue(8'h01, 16'hF0F0, 16'h0FF0);
        checks++; if (rout !== 16'h00F0 || flags !== 5'b00010) begin errors++; $display("FAIL and: got %h/%b required 00f0/00010", rout, flags); end
        issue(8'h03, 16'hFFFF, 16'hFFFF);
        checks++; if (rout !== 16'h0000 || flags !== 5'b01010) begin errors++; $display("FAIL xor: got %h/%b required 0000/01010", rout, flags); end
        issue(8'h04, 16'h0000, 16'h1234);
        checks++; if (rout !== 16'hFFFF || flags !== 5'b10010) begin errors++; $display("FAIL not: got %h/%b required ffff/10010", rout, flags); end
        issue(8'h02, 16'h0001, 16'h0100);
        checks++; if (rout !== 16'h0101 || flags !== 5'b00010) begin errors++; $display("FAIL or: got %h/%b required 0101/00010", rout, flags); end
    endtask

    task automatic test_sub();
        issue(8'h09, 16'h0005, 16'h0007);
        checks++; if (rout !== 16'hFFFE || flags !== 5'b10010) begin errors++; $display("FAIL sub_borrow: got %h/%b required fffe/10010", rout, flags); end
        issue(8'h09, 16'h8000, 16'h0001);
        checks++; if (rout !== 16'h7FFF || flags !== 5'b00111) begin errors++; $display("FAIL sub_ovf: got %h/%b required 7fff/00111", rout, flags); end
        issue(8'h06, 16'h0001, 16'h0001);
        checks++; if (rout !== 16'h0002 || flags !== 5'b00110) begin errors++; $display("FAIL addu_keeps_f: got %h/%b required 0002/00110", rout, flags); end
    endtask

    task automatic test_shift();
        issue(8'h0F, 16'h0014, 16'h8000);
        checks++; if (rout !== 16'hFFFF || flags !== 5'b10110) begin errors++; $display("FAIL arsh_big: got %h/%b required ffff/10110", rout, flags); end
        issue(8'h84, 16'h0010, 16'h0001);
        checks++; if (rout !== 16'h0000 || flags !== 5'b01110) begin errors++; $display("FAIL lsh_big: got %h/%b required 0000/01110", rout, flags); end
        issue(8'h08, 16'h0004, 16'h8000);
        checks++; if (rout !== 16'h0800) begin errors++; $display("FAIL rsh: got %h required 0800", rout); end
        issue(8'h0C, 16'h0003, 16'h0001);
        checks++; if (rout !== 16'h0008) begin errors++; $display("FAIL alsh: got %h required 0008", rout); end
        issue(8'h0F, 16'h0004, 16'h8000);
        checks++; if (rout !== 16'hF800 || flags !== 5'b10110) begin errors++; $display("FAIL arsh: got %h/%b required f800/10110", rout, flags); end
        issue(8'h08, 16'h0010, 16'hFFFF);
        checks++; if (rout !== 16'h0000 || flags !== 5'b01110) begin errors++; $display("FAIL rsh_big: got %h/%b required 0000/01110", rout, flags); end
        issue(8'h84, 16'h000F, 16'h0001);
        checks++; if (rout !== 16'h8000) begin errors++; $display("FAIL lsh_15: got %h required 8000", rout); end
    endtask

    task automatic test_mul();
        int cyc;
        logic busy_bad;
        // flags entering: 10110 (N=1 F=1 L=1 C=0)
        issue(8'h0E, 16'h0100, 16'h0100);
        cyc = 0; busy_bad = 1'b0;
        // Inputs change and in_valid pulses during MUL; both must be ignored.
        r1 = 16'hFFFF; r2 = 16'hFFFF; opcode = 8'h05; in_valid = 1'b1;
        while (!out_valid && cyc < 40) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (cyc == 3) in_valid = 1'b0;
        end
        checks++; if (cyc !== 16) begin errors++; $display("FAIL mul_latency: got %0d edges required 16", cyc); end
        checks++; if (busy_bad !== 1'b0) begin errors++; $display("FAIL mul_in_ready: in_ready rose during MUL"); end
        checks++; if (rout !== 16'h0000 || flags !== 5'b01111) begin errors++; $display("FAIL mul_overflow: got %h/%b required 0000/01111", rout, flags); end
        issue(8'h0E, 16'h0003, 16'h0005);
        cyc = 0;
        while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        checks++; if (rout !== 16'h000F || flags !== 5'b00110) begin errors++; $display("FAIL mul_small: got %h/%b required 000f/00110", rout, flags); end
        issue(8'h0E, 16'hFFFF, 16'hFFFF);
        cyc = 0;
        while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        checks++; if (rout !== 16'h0001 || flags !== 5'b00111) begin errors++; $display("FAIL mul_max: got %h/%b required 0001/00111", rout, flags); end
    endtask

    task automatic test_unknown();
        issue(8'hFF, 16'h1111, 16'h2222);
        checks++; if (op_err !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL unk_pulse: op_err=%b out_valid=%b required 1/1", op_err, out_valid); end
        checks++; if (rout !== 16'h0001 || flags !== 5'b00111) begin errors++; $display("FAIL unk_kept: got %h/%b required 0001/00111", rout, flags); end
        @(posedge clk); #1;
        checks++; if (op_err !== 1'b0) begin errors++; $display("FAIL unk_pulse_width: op_err=%b required 0", op_err); end
        issue(8'h0A, 16'h1111, 16'h2222);
        checks++; if (op_err !== 1'b1 || rout !== 16'h0001) begin errors++; $display("FAIL unk_0a: op_err=%b rout=%h required 1/0001", op_err, rout); end
        issue(8'h05, 16'h0001, 16'h0001);
        checks++; if (op_err !== 1'b0 || rout !== 16'h0002) begin errors++; $display("FAIL known_no_err: op_err=%b rout=%h required 0/0002", op_err, rout); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        opcode = 8'h05; r1 = 16'h0001; r2 = 16'h0001; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        in_valid = 1'b0;
        checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_throughput: got %0d pulses required 3", pulses); end
    endtask

    task automatic test_reset_mid_mul();
        int seen = 0;
        issue(8'h0E, 16'h0003, 16'h0005);
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++; if (rout !== 16'h0 || flags !== 5'b0 || out_valid !== 1'b0 || op_err !== 1'b0) begin
            errors++; $display("FAIL midmul_reset: rout=%h flags=%b ov=%b err=%b required 0", rout, flags, out_valid, op_err);
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midmul_idle: in_ready=%b required 1", in_ready); end
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midmul_no_valid: got %0d pulses required 0", seen); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_addc();
        test_cmp();
        test_logic();
        test_sub();
        test_shift();
        test_mul();
        test_unknown();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
